// File: rtl/microc_stk_pkg.sv
// Shared constants for the microc_stk core: instruction field positions,
// ALU operation codes and the fixed instruction/register-file geometry.
package microc_stk_pkg;

  localparam int IW   = 16;
  localparam int NREG = 16;

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_NOTA  = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_NEGA  = 3'b110;
  localparam logic [2:0] ALU_NEGB  = 3'b111;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 10;
  localparam int RA1_HI = 11;
  localparam int RA1_LO = 8;
  localparam int RA2_HI = 7;
  localparam int RA2_LO = 4;
  localparam int WA3_HI = 3;
  localparam int WA3_LO = 0;
  localparam int IMM_HI = 11;
  localparam int IMM_LO = 4;

endpackage

// File: rtl/microc_stk_lib.sv
// Width-parametrised building blocks shared with the basic core:
// register file, ALU, 2:1 mux, PC register and program ROM.
module regfile
  import microc_stk_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         we3,
  input  logic [3:0]   ra1,
  input  logic [3:0]   ra2,
  input  logic [3:0]   wa3,
  input  logic [W-1:0] wd3,
  output logic [W-1:0] rd1,
  output logic [W-1:0] rd2
);
  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (we3 && wa3 != 4'd0)
      regs[wa3] <= wd3;
  end

  assign rd1 = (ra1 == 4'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 4'd0) ? '0 : regs[ra2];
endmodule

module alu
  import microc_stk_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] y
);
  always_comb begin
    y = a;
    case (op)
      ALU_PASSA: y = a;
      ALU_NOTA:  y = ~a;
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_NEGA:  y = '0 - a;
      ALU_NEGB:  y = '0 - b;
      default:   y = a;
    endcase
  end
endmodule

module mux2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         s,
  output logic [W-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

module registro #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= '0;
    else
      q <= d;
  end
endmodule

module memprog_p
  import microc_stk_pkg::*;
#(
  parameter int AW   = 10,
  parameter     PROG = "progfile.dat"
) (
  input  logic [AW-1:0] a,
  output logic [IW-1:0] rd
);
  // Contents are placed by the program loader of the target flow (PROG image).
  logic [IW-1:0] mem [2**AW];

  assign rd = mem[a];
endmodule

// File: rtl/microc_stk_ret_stack.sv
// Hardware return-address stack: push on legal call, pop on legal return,
// sticky error on overflow, underflow or simultaneous call/return.
module ret_stack #(
  parameter int SD = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] ret_addr,
  output logic [AW-1:0] top,
  output logic          push_ok,
  output logic          pop_ok,
  output logic          full,
  output logic          empty,
  output logic          err
);
  localparam int SPW = $clog2(SD) + 1;

  logic [SPW-1:0] sp_reg, sp_next;
  logic           err_reg, err_next;
  logic [SPW-2:0] top_idx;
  logic [AW-1:0]  mem [SD];

  assign full    = (sp_reg == SPW'(SD));
  assign empty   = (sp_reg == '0);
  assign push_ok = call && !ret && !full;
  assign pop_ok  = ret && !call && !empty;
  assign err     = err_reg;

  // Low sp bits wrap to SD-1 when sp==SD, so top stays valid when full.
  assign top_idx = sp_reg[SPW-2:0] - (SPW-1)'(1);
  assign top     = mem[top_idx];

  always_comb begin
    sp_next = sp_reg;
    if (push_ok)
      sp_next = sp_reg + SPW'(1);
    else if (pop_ok)
      sp_next = sp_reg - SPW'(1);
    err_next = err_reg | (call & ret) | (ret & ~call & empty) | (call & ~ret & full);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      sp_reg  <= sp_next;
      err_reg <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[sp_reg[SPW-2:0]] <= ret_addr;
  end

endmodule

// File: rtl/microc_stk.sv
// Single-cycle microcontroller datapath with registered zero flag and a
// return-address stack for call/return; control comes from outside.
module microc_stk
  import microc_stk_pkg::*;
#(
  parameter int DW   = 8,
  parameter int AW   = 10,
  parameter int SD   = 8,
  parameter     PROG = "progfile.dat"
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_inc,
  input  logic       s_inm,
  input  logic       we3,
  input  logic       wez,
  input  logic [2:0] Op,
  input  logic       s_call,
  input  logic       s_ret,
  output logic [5:0] Opcode,
  output logic       z,
  output logic       stk_full,
  output logic       stk_empty,
  output logic       stk_err
);
  logic [IW-1:0] instr;
  logic [AW-1:0] pc_reg, pc_next, pc_inc, pc_seq, target, ret_top;
  logic [DW-1:0] rd1, rd2, alu_out, imm_ext, wd3;
  logic          push_ok, pop_ok;
  logic          z_reg;

  registro #(.W(AW)) u_pc (.clk(clk), .reset(reset), .d(pc_next), .q(pc_reg));

  memprog_p #(.AW(AW), .PROG(PROG)) u_rom (.a(pc_reg), .rd(instr));

  assign Opcode = instr[OPC_HI:OPC_LO];
  assign target = instr[AW-1:0];
  assign pc_inc = pc_reg + AW'(1);

  mux2 #(.W(AW)) u_pcmux (.d0(target), .d1(pc_inc), .s(s_inc), .y(pc_seq));

  ret_stack #(.SD(SD), .AW(AW)) u_stk (
    .clk(clk), .reset(reset), .call(s_call), .ret(s_ret), .ret_addr(pc_inc),
    .top(ret_top), .push_ok(push_ok), .pop_ok(pop_ok),
    .full(stk_full), .empty(stk_empty), .err(stk_err)
  );

  // Any stack request overrides s_inc; failed requests fall through to PC+1.
  always_comb begin
    pc_next = pc_seq;
    if (s_call || s_ret)
      pc_next = pc_inc;
    if (pop_ok)
      pc_next = ret_top;
    else if (push_ok)
      pc_next = target;
  end

  regfile #(.W(DW)) u_rf (
    .clk(clk), .we3(we3),
    .ra1(instr[RA1_HI:RA1_LO]), .ra2(instr[RA2_HI:RA2_LO]), .wa3(instr[WA3_HI:WA3_LO]),
    .wd3(wd3), .rd1(rd1), .rd2(rd2)
  );

  alu #(.W(DW)) u_alu (.a(rd1), .b(rd2), .op(Op), .y(alu_out));

  assign imm_ext = DW'(instr[IMM_HI:IMM_LO]);

  mux2 #(.W(DW)) u_wdmux (.d0(alu_out), .d1(imm_ext), .s(s_inm), .y(wd3));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      z_reg <= 1'b0;
    else if (wez)
      z_reg <= (alu_out == '0);
  end

  assign z = z_reg;

endmodule

// File: tb/tb_microc_stk.sv
// Randomised and directed bench for microc_stk against a queue-based
// behavioural model of PC, register file, zero flag and return stack.
module tb_microc_stk;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int SD = 8;
  localparam int NW = 1 << AW;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_inc = 1'b0, s_inm = 1'b0, we3 = 1'b0, wez = 1'b0;
  logic       s_call = 1'b0, s_ret = 1'b0;
  logic [2:0] Op = 3'd0;
  logic [5:0] Opcode;
  logic       z, stk_full, stk_empty, stk_err;

  microc_stk #(.DW(DW), .AW(AW), .SD(SD)) dut (
    .clk(clk), .reset(reset), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
    .Op(Op), .s_call(s_call), .s_ret(s_ret), .Opcode(Opcode), .z(z),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tx = 0;

  logic [15:0]   rom_m [NW];
  logic [DW-1:0] regs_m [16];
  int            pc_m = 0;
  bit            z_m = 1'b0;
  bit            err_m = 1'b0;
  int            stk_m [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Upper nibble of each word carries its own address, so Opcode[5:2] shows the PC.
  task automatic rom_wr(input int a, input logic [11:0] low);
    rom_m[a] = {4'(a), low};
    dut.u_rom.mem[a] = {4'(a), low};
  endtask

  function automatic logic [DW-1:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      3'd0: return a;
      3'd1: return ~a;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return -a;
      default: return -b;
    endcase
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_opcode"}, 32'(Opcode), 32'(rom_m[pc_m][15:10]));
    chk({tag, "_z"}, 32'(z), 32'(z_m));
    chk({tag, "_full"}, 32'(stk_full), 32'(stk_m.size() == SD));
    chk({tag, "_empty"}, 32'(stk_empty), 32'(stk_m.size() == 0));
    chk({tag, "_err"}, 32'(stk_err), 32'(err_m));
  endtask

  task automatic model_reset();
    pc_m = 0;
    z_m = 1'b0;
    err_m = 1'b0;
    stk_m.delete();
  endtask

  task automatic step(input bit inc, input bit inm, input bit w3, input bit wz,
                      input logic [2:0] op, input bit call, input bit ret);
    logic [15:0]   ins;
    logic [DW-1:0] a, b, y, wd;
    int            wa, nxt;
    s_inc = inc; s_inm = inm; we3 = w3; wez = wz; Op = op; s_call = call; s_ret = ret;
    ins = rom_m[pc_m];
    a   = regs_m[ins[11:8]];
    b   = regs_m[ins[7:4]];
    y   = alu_ref(op, a, b);
    wd  = inm ? DW'(ins[11:4]) : y;
    wa  = int'(ins[3:0]);
    nxt = (pc_m + 1) % NW;
    if (call && ret) begin
      pc_m = nxt; err_m = 1'b1;
    end else if (ret) begin
      if (stk_m.size() > 0) pc_m = stk_m.pop_back();
      else begin pc_m = nxt; err_m = 1'b1; end
    end else if (call) begin
      if (stk_m.size() < SD) begin
        stk_m.push_back(nxt);
        pc_m = int'(ins[3:0]);
      end else begin
        pc_m = nxt; err_m = 1'b1;
      end
    end else begin
      pc_m = inc ? nxt : int'(ins[3:0]);
    end
    if (w3 && wa != 0) regs_m[wa] = wd;
    if (wz) z_m = (y == '0);
    @(posedge clk);
    #1;
    tx++;
    $display("tx %0d op=%0d inc=%0b inm=%0b we3=%0b wez=%0b call=%0b ret=%0b -> pc=%0d sp=%0d z=%0b err=%0b",
             tx, op, inc, inm, w3, wz, call, ret, pc_m, stk_m.size(), z_m, err_m);
    chk_state("step");
  endtask

  // Reset is asserted mid-cycle and must act before the next rising edge.
  task automatic mid_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    chk_state("rst");
    @(posedge clk);
    #1;
    chk_state("rst_hold");
    reset = 1'b1;
  endtask

  function automatic logic [3:0] rnd_field();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    int prev;
    int sel;
    for (int i = 0; i < 16; i++) regs_m[i] = '0;
    for (int i = 0; i < NW; i++) rom_wr(i, {8'($urandom_range(0, 255)), 4'((i % 15) + 1)});
    repeat (2) @(posedge clk);
    #1;
    chk_state("por");
    reset = 1'b1;

    // Give every register a known value.
    for (int i = 0; i < 15; i++) step(1, 1, 1, 0, 3'd0, 0, 0);

    for (int i = 0; i < NW; i++) rom_wr(i, 12'h000);
    rom_wr(0, {8'h05, 4'h1});
    rom_wr(1, {8'h05, 4'h2});
    rom_wr(2, 12'h123);
    rom_wr(3, 12'h123);
    rom_wr(4, 12'h00C);
    rom_wr(5, {8'hFF, 4'h0});
    rom_wr(6, 12'h004);
    rom_wr(7, {8'hFF, 4'h4});
    rom_wr(8, 12'h405);
    mid_reset();

    step(1, 1, 1, 0, 3'd0, 0, 0);
    step(1, 1, 1, 0, 3'd0, 0, 0);
    step(1, 0, 1, 1, 3'b011, 0, 0);
    chk("sub_z", 32'(z), 32'd1);
    step(1, 0, 1, 1, 3'b010, 0, 0);
    chk("add_z", 32'(z), 32'd0);
    step(0, 0, 0, 0, 3'd0, 1, 0);
    chk("call_pc", 32'(Opcode[5:2]), 32'd12);
    chk("call_sp", 32'(stk_empty), 32'd0);
    step(0, 0, 0, 0, 3'd0, 0, 1);
    chk("ret_pc", 32'(Opcode[5:2]), 32'd5);
    chk("ret_empty", 32'(stk_empty), 32'd1);
    chk("ret_err", 32'(stk_err), 32'd0);
    step(1, 1, 1, 0, 3'd0, 0, 0);
    step(1, 0, 0, 1, 3'd0, 0, 0);
    chk("r0_z", 32'(z), 32'd1);
    step(1, 1, 1, 0, 3'd0, 0, 0);
    step(1, 0, 1, 1, 3'b001, 0, 0);
    chk("zext_z", 32'(z), 32'd0);
    repeat (7) step(1, 0, 0, 0, 3'd0, 0, 0);
    chk("wrap_pc", 32'(Opcode[5:2]), 32'd0);
    step(1, 0, 0, 1, 3'd0, 0, 0);
    step(1, 0, 0, 0, 3'd0, 0, 1);
    chk("unf_pc", 32'(Opcode[5:2]), 32'd2);
    chk("unf_err", 32'(stk_err), 32'd1);
    repeat (3) step(1, 0, 0, 0, 3'd0, 0, 0);
    chk("pre_rst_pc", 32'(Opcode[5:2]), 32'd5);
    mid_reset();
    chk("rst_pc", 32'(Opcode[5:2]), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    chk("rst_err", 32'(stk_err), 32'd0);

    step(1, 0, 0, 0, 3'd0, 1, 1);
    chk("cfl_pc", 32'(Opcode[5:2]), 32'd1);
    chk("cfl_empty", 32'(stk_empty), 32'd1);
    chk("cfl_err", 32'(stk_err), 32'd1);

    mid_reset();
    repeat (SD) step(0, 0, 0, 0, 3'd0, 1, 0);
    chk("full8", 32'(stk_full), 32'd1);
    chk("err8", 32'(stk_err), 32'd0);
    prev = pc_m;
    step(0, 0, 0, 0, 3'd0, 1, 0);
    chk("ovf_pc", 32'(Opcode[5:2]), 32'((prev + 1) % NW));
    chk("ovf_full", 32'(stk_full), 32'd1);
    chk("ovf_err", 32'(stk_err), 32'd1);
    repeat (SD) step(0, 0, 0, 0, 3'd0, 0, 1);
    chk("ovf_empty", 32'(stk_empty), 32'd1);
    chk("ovf_err_sticky", 32'(stk_err), 32'd1);

    for (int i = 0; i < NW; i++) rom_wr(i, {rnd_field(), rnd_field(), rnd_field()});
    mid_reset();
    for (int n = 0; n < 1200; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        mid_reset();
      end else begin
        sel = int'($urandom_range(0, 99));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             (sel < 20) || (sel == 99), (sel >= 20 && sel < 36) || (sel == 99));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
